// File: rtl/prbs_pkg.sv
// Shared constants, FSM state type and LFSR step function for the PRBS9 source.
package prbs_pkg;

  localparam int PRBS_LEN = 9;
  localparam int SEQ_LEN  = 511;
  localparam int TAP_HI   = 8;
  localparam int TAP_LO   = 4;

  localparam logic [PRBS_LEN-1:0] SEED_I = 9'h1AA;
  localparam logic [PRBS_LEN-1:0] SEED_Q = 9'h1FE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  // Fibonacci step for x^9 + x^5 + 1: shift left, feed back tap8 ^ tap4.
  function automatic logic [PRBS_LEN-1:0] lfsr_next(input logic [PRBS_LEN-1:0] v);
    return {v[PRBS_LEN-2:0], v[TAP_HI] ^ v[TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// 9-bit PRBS9 shift register with seed load, step and all-zero lockup recovery.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] SEED = SEED_I
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PRBS_LEN-1:0] load_val,
  input  logic                step,
  output logic [PRBS_LEN-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      // A zero seed would lock the register, so the default seed stands in.
      q <= (load_val == '0) ? SEED : load_val;
    end else if (q == '0) begin
      q <= SEED;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/prbs_gen.sv
// PRBS9 transmit source: one bit per enable strobe, period marking/counting, graceful stop.
// Optional feature: define PRBS_ERR_INJECT_EN to let err_inject invert the next emitted bit.
module prbs_gen
  import prbs_pkg::*;
#(
  parameter logic [PRBS_LEN-1:0] SEED  = SEED_I,
  parameter int                  CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                enable,
  input  logic                seed_load,
  input  logic [PRBS_LEN-1:0] seed_in,
  input  logic                err_inject,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                seq_start,
  output logic [CNT_W-1:0]    period_cnt,
  output logic                busy
);

  localparam logic [PRBS_LEN-1:0] PHASE_LAST = PRBS_LEN'(SEQ_LEN - 1);

  state_t              state;
  logic [PRBS_LEN-1:0] lfsr;
  logic [PRBS_LEN-1:0] phase;
  logic                active;
  logic                emit;
  logic                inj;

  assign active = (state != IDLE);
  assign busy   = active;
  assign emit   = active && enable && !seed_load;

  prbs_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (seed_load),
    .load_val(seed_in),
    .step    (emit),
    .q       (lfsr)
  );

`ifdef PRBS_ERR_INJECT_EN
  logic inj_flag;

  // Sticky request; a pulse coinciding with an emission corrupts that emission.
  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      inj_flag <= 1'b0;
    end else if (emit) begin
      inj_flag <= 1'b0;
    end else if (err_inject) begin
      inj_flag <= 1'b1;
    end
  end

  assign inj = inj_flag | err_inject;
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject;
  assign inj               = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      period_cnt <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      seq_start  <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      seq_start <= 1'b0;
      if (seed_load) begin
        phase      <= '0;
        period_cnt <= '0;
      end else begin
        if (emit) begin
          bit_valid <= 1'b1;
          bit_out   <= lfsr[TAP_HI] ^ inj;
          seq_start <= (phase == '0);
          if (phase == PHASE_LAST) begin
            phase <= '0;
            if (period_cnt != '1) period_cnt <= period_cnt + 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        // Stopping only completes on the last bit of a period, so restarts begin at phase 0.
        case (state)
          IDLE: if (run) state <= RUN;
          RUN:  if (!run) state <= STOP;
          STOP: begin
            if (run) state <= RUN;
            else if (emit && phase == PHASE_LAST) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prbs_gen.sv
// Directed self-checking bench for prbs_gen with a reference PRBS9 model.
module tb_prbs_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        enable = 1'b0;
  logic        seed_load = 1'b0;
  logic [8:0]  seed_in = 9'h000;
  logic        err_inject = 1'b0;
  logic        bit_out;
  logic        bit_valid;
  logic        seq_start;
  logic [15:0] period_cnt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] m_lfsr;
  int         m_phase;
  int         m_cnt;
  logic       last_bit;

  prbs_gen dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .enable    (enable),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .err_inject(err_inject),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .seq_start (seq_start),
    .period_cnt(period_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input logic [8:0] s);
    m_lfsr  = s;
    m_phase = 0;
    m_cnt   = 0;
  endtask

  // One strobe: drive enable, then compare the emitted bit against the model.
  task automatic emit_chk(input string tag, input logic inv);
    logic b;
    logic st;
    enable = 1'b1;
    tick();
    b      = m_lfsr[8];
    st     = (m_phase == 0);
    m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
    if (m_phase == 510) begin
      m_phase = 0;
      m_cnt++;
    end else begin
      m_phase++;
    end
    last_bit = b ^ inv;
    check({tag, "_valid"}, bit_valid, 1);
    check({tag, "_bit"}, bit_out, last_bit);
    check({tag, "_start"}, seq_start, st);
    check({tag, "_cnt"}, period_cnt, m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; enable = 1'b0; seed_load = 1'b0; err_inject = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_seed(9'h1AA);
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_bit", bit_out, 0);
    check("rst_valid", bit_valid, 0);
    check("rst_start", seq_start, 0);
    check("rst_cnt", period_cnt, 0);
    check("rst_busy", busy, 0);

    // Enable ignored in IDLE
    enable = 1'b1;
    tick();
    check("idle_valid", bit_valid, 0);
    enable = 1'b0;

    // Sequence start and two full periods
    run = 1'b1;
    tick();
    check("run_busy", busy, 1);
    emit_chk("p_b1", 0);
    check("first_bit1", bit_out, 1);
    check("first_start", seq_start, 1);
    emit_chk("p_b2", 0);
    check("first_bit2", bit_out, 1);
    emit_chk("p_b3", 0);
    check("first_bit3", bit_out, 0);
    for (int i = 4; i <= 1022; i++) begin
      emit_chk("period", 0);
      if (i == 512) begin
        check("b512_start", seq_start, 1);
        check("b512_bit", bit_out, 1);
      end
    end
    check("period_cnt2", period_cnt, 2);

    // Graceful stop after bit 100
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 1; i <= 100; i++) emit_chk("stop_run", 0);
    run = 1'b0;
    for (int i = 101; i <= 511; i++) emit_chk("stop_drain", 0);
    check("stop_busy", busy, 0);
    check("stop_cnt", period_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      enable = i[0];
      tick();
      check("stop_novalid", bit_valid, 0);
    end
    enable = 1'b0;
    run = 1'b1;
    tick();
    emit_chk("restart", 0);
    check("restart_start", seq_start, 1);
    check("restart_bit", bit_out, 1);
    for (int i = 0; i < 20; i++) emit_chk("pre_seed", 0);

    // Seed load mid-run, enable ignored that cycle
    seed_load = 1'b1;
    seed_in   = 9'h1FE;
    enable    = 1'b1;
    tick();
    seed_load = 1'b0;
    model_seed(9'h1FE);
    check("seed_novalid", bit_valid, 0);
    check("seed_cnt", period_cnt, 0);
    emit_chk("seed_q", 0);
    check("seed_q_bit", bit_out, 1);
    check("seed_q_start", seq_start, 1);
    for (int i = 0; i < 8; i++) emit_chk("seed_q", 0);

    // Zero seed falls back to the default seed
    seed_load = 1'b1;
    seed_in   = 9'h000;
    tick();
    seed_load = 1'b0;
    model_seed(9'h1AA);
    emit_chk("seed0", 0);
    check("seed0_b1", bit_out, 1);
    emit_chk("seed0", 0);
    check("seed0_b2", bit_out, 1);
    emit_chk("seed0", 0);
    check("seed0_b3", bit_out, 0);

    // Sparse enable: one strobe every 4 cycles
    for (int s = 0; s < 16; s++) begin
      emit_chk("sparse", 0);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("sparse_novalid", bit_valid, 0);
        check("sparse_hold", bit_out, last_bit);
        check("sparse_nostart", seq_start, 0);
      end
    end

`ifdef PRBS_ERR_INJECT_EN
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) emit_chk("inj_pre", 0);
    err_inject = 1'b1;
    emit_chk("inj_b10", 1);
    err_inject = 1'b0;
    for (int i = 11; i <= 20; i++) emit_chk("inj_post", 0);
    enable = 1'b0;
    err_inject = 1'b1;
    tick();
    tick();
    err_inject = 1'b0;
    tick();
    emit_chk("inj_merge", 1);
    emit_chk("inj_merge_clean", 0);
    emit_chk("inj_merge_clean", 0);
`else
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) emit_chk("noinj_pre", 0);
    err_inject = 1'b1;
    emit_chk("noinj_b10", 0);
    enable = 1'b0;
    tick();
    err_inject = 1'b0;
    for (int i = 0; i < 10; i++) emit_chk("noinj_post", 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_gen.md
Name: prbs_gen

Overview:
- PRBS9 transmit-side source for the QPSK link.
- Generates the 511-bit maximal-length sequence that the downstream BER checker aligns to and compares against.
- One instance per branch: I uses seed 9'h1AA, Q uses 9'h1FE.
- Emits one bit per `enable` strobe from the symbol-rate divider, with period-start marking, period counting and graceful stop at a period boundary.

Parameters:
- SEED, 9'h1AA, LFSR value after reset; also substituted when a zero seed is loaded.
- CNT_W, 16, width of `period_cnt`.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  level; high = generate, low = stop at end of current period
- enable  in  1  advance strobe, one bit per strobe
- seed_load  in  1  pulse; load `seed_in` into LFSR
- seed_in  in  9  new seed
- err_inject  in  1  pulse; corrupt next emitted bit (feature-dependent)
- bit_out  out  1  PRBS bit, registered
- bit_valid  out  1  `bit_out` updated this cycle
- seq_start  out  1  high with the first bit of each 511-bit period
- period_cnt  out  CNT_W  completed periods, saturating
- busy  out  1  state != IDLE

Behaviour:
- Reset values: lfsr=SEED, phase=0, state=IDLE, bit_out=0, bit_valid=0, seq_start=0, period_cnt=0, busy=0.
- LFSR (Fibonacci, x^9+x^5+1):
  - Emitted bit = lfsr[8].
  - On advance: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}.
  - Period is exactly 511 advances.
- phase: 9-bit counter 0..510.
  - Increments on each emitted bit.
  - Wraps 510 -> 0; on wrap, period_cnt += 1, saturating at all-ones.
- Emit: in RUN or STOP, when enable=1:
  - Next cycle: bit_valid=1, bit_out=lfsr[8] (pre-advance value), seq_start=(phase==0).
  - Same edge: LFSR advances and phase steps.
  - Latency enable -> bit_valid is 1 cycle.
  - bit_valid, seq_start and bit_valid-qualified outputs are single-cycle; bit_out holds its value between strobes.
- FSM:
  - IDLE: run=1 -> RUN. No emission in IDLE; enable is ignored.
  - RUN: run=0 -> STOP (the emission in that cycle still occurs if enable=1).
  - STOP: keeps emitting on enable until the bit with phase==510 is emitted, then -> IDLE. run=1 in STOP -> RUN, no gap.
  - Net effect: stopping always lands on phase=0, so the next start begins a fresh period with seq_start.
- seed_load (any state):
  - Highest priority; enable ignored that cycle, no emission.
  - lfsr <= (seed_in==0) ? SEED : seed_in; phase <= 0; period_cnt <= 0; state unchanged.
- Lockup guard: if lfsr==0 is ever observed, reload SEED on the next edge.
- rst mid-operation: all state to reset values on that edge; a pending err_inject is dropped.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- Defined:
  - An err_inject pulse sets a sticky flag.
  - The next emitted bit is driven inverted (the LFSR itself is not perturbed) and the flag clears.
  - Pulses arriving while the flag is set are merged, so at most one corruption per emitted bit.
  - If err_inject and an emission occur in the same cycle, that emission is corrupted.
  - seed_load clears the flag.
- Undefined: err_inject port still present but ignored; output is always the clean sequence.

Decomposition:
- Package prbs_pkg:
  - PRBS_LEN=9, SEQ_LEN=511.
  - Tap indices 8 and 4.
  - SEED_I=9'h1AA, SEED_Q=9'h1FE.
  - FSM state typedef {IDLE, RUN, STOP}.
- Sub-module prbs_lfsr:
  - 9-bit register with load, step and zero-guard.
  - prbs_gen wraps it with the phase counter, FSM, output registers and injection logic.

Test Plan:
- Sequence start: reset, run=1, enable every cycle -> first bit_valid cycle has bit_out=1 and seq_start=1; first three bits are 1,1,0.
- Period check: 1022 strobes -> seq_start on bits 1 and 512 only; bit 512 equals bit 1; period_cnt=2 after bit 1022. Compare against a software LFSR model.
- Graceful stop: drop run after bit 100 -> bits continue through bit 511, busy falls; no bit_valid while enable keeps toggling; run=1 again -> next bit has seq_start=1, bit_out=1.
- Seed load: seed_load with seed_in=9'h1FE mid-run -> period_cnt=0, next bit=1 with seq_start=1; seed_in=0 -> sequence restarts from 9'h1AA.
- Sparse enable: enable every 4th cycle -> exactly one bit_valid per strobe, 1-cycle latency, bit_out stable between strobes.
- Injection (PRBS_ERR_INJECT_EN): err_inject at bit 10 -> bit 10 inverted, bits 11+ match the model. Two pulses before one emission -> one error. Macro off -> zero mismatches.
